// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: applies up to STEP bit positions per clock to an XLEN-bit operand.
// Ops: SLL, SRL, SRA, and ROR when ITERATIVE_SHIFTER_ROTATE_EN is defined (else type 11 is
// reserved: one SHIFT cycle, result 0). Handshake: start_i in idle, busy_o, one-cycle done_o.
module iterative_shifter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [XLEN-1:0]         a_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  input  logic [1:0]              type_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         r_o
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  // One extra bit so STEP == XLEN is representable in the comparison.
  localparam logic [SHAMT_W:0] StepAmt = (SHAMT_W+1)'(STEP);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      acc_q, acc_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [1:0]           op_q, op_d;
  logic                 sgn_q, sgn_d;
  logic [XLEN-1:0]      r_q, r_d;

  logic                 rem_gt_step;
  logic [SHAMT_W-1:0]   d;
  logic [XLEN-1:0]      step_res;
  logic                 last;

  // Per-cycle distance: STEP while more than STEP remains, else the remainder.
  always_comb begin
    rem_gt_step = ({1'b0, rem_q} > StepAmt);
    d           = rem_gt_step ? StepAmt[SHAMT_W-1:0] : rem_q;
  end

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
  localparam logic [SHAMT_W:0] XlenAmt = (SHAMT_W+1)'(XLEN);
  logic [SHAMT_W:0] rot_amt;
  // Left shift by XLEN yields zero, so d == 0 rotates to the operand itself.
  always_comb rot_amt = XlenAmt - {1'b0, d};
`endif

  // One partial shift of the accumulator; SRA fills with the captured sign every step.
  always_comb begin
    step_res = acc_q;
    unique case (op_q)
      OpSll:   step_res = acc_q << d;
      OpSrl:   step_res = acc_q >> d;
      OpSra:   step_res = (acc_q >> d) | (sgn_q ? ~({XLEN{1'b1}} >> d) : '0);
      default: begin
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
        step_res = (acc_q >> d) | (acc_q << rot_amt);
`else
        step_res = '0;
`endif
      end
    endcase
  end

  // Final step when the remainder fits in one cycle (reserved op always finishes at once).
  always_comb begin
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    last = !rem_gt_step;
`else
    last = !rem_gt_step || (op_q == 2'b11);
`endif
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    r_d     = r_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d   = a_i;
          rem_d   = shamt_i;
          op_d    = type_i;
          sgn_d   = a_i[XLEN-1];
          state_d = StShift;
        end
      end
      StShift: begin
        busy_o = 1'b1;
        acc_d  = step_res;
        rem_d  = rem_q - d;
        if (last) begin
          r_d     = step_res;
          state_d = StDone;
        end
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      r_q     <= r_d;
    end
  end

  assign r_o = r_q;

endmodule
